// File: rtl/ex_ctrl_pkg.sv
// Shared constants and FSM state encoding for the EX-stage sequencing controller.
// Watchdog support elsewhere is compiled in only with EX_SEQ_TIMEOUT_EN.
package ex_ctrl_pkg;

    localparam int OPC_W          = 6;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int CNT_W          = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_BUSY      = 2'd1;
    localparam logic [1:0] ST_DONE_WAIT = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        BUSY      = ST_BUSY,
        DONE_WAIT = ST_DONE_WAIT
    } state_t;

endpackage

// File: rtl/ex_seq_timer.sv
// Saturating BUSY-duration counter plus optional watchdog compare.
// The watchdog exists only when EX_SEQ_TIMEOUT_EN is defined; otherwise expire is tied low.
module ex_seq_timer
`ifdef EX_SEQ_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = ex_ctrl_pkg::TIMEOUT_CYCLES
)
`endif
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          enable,
    output logic [ex_ctrl_pkg::CNT_W-1:0] count,
    output logic                          expire
);
    import ex_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

`ifdef EX_SEQ_TIMEOUT_EN
    // Separate from count so timeouts above 255 cycles still work.
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (clear) begin
            wd_cnt <= '0;
        end else if (enable) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign expire = enable && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

endmodule

// File: rtl/ex_seq_ctrl.sv
// EX-stage sequencer: issues multi-cycle ALU ops, stalls the front end and gates EXMEM loads.
// Define EX_SEQ_TIMEOUT_EN to compile in the BUSY watchdog and sticky timeout_err.
module ex_seq_ctrl #(
    parameter int OPC_W          = ex_ctrl_pkg::OPC_W,
    parameter int TIMEOUT_CYCLES = ex_ctrl_pkg::TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idex_valid,
    input  logic [OPC_W-1:0] opcode,
    input  logic             multi_cycle,
    input  logic             alu_done,
    input  logic             flush,
    input  logic             exmem_ready,
    output logic             alu_start,
    output logic [OPC_W-1:0] alu_opcode,
    output logic             stall,
    output logic             exmem_we,
    output logic             bubble,
    output logic [7:0]       busy_cycles,
    output logic             timeout_err
);
    import ex_ctrl_pkg::*;

    state_t state;
    state_t state_next;
    logic   issue;
    logic   in_busy;
    logic   expire;

    assign in_busy = (state == BUSY);

    ex_seq_timer
`ifdef EX_SEQ_TIMEOUT_EN
    #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    )
`endif
    u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (issue),
        .enable (in_busy),
        .count  (busy_cycles),
        .expire (expire)
    );

    // Flush overrides everything, including an alu_done arriving in the same cycle.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        exmem_we   = 1'b0;
        bubble     = 1'b0;
        issue      = 1'b0;
        if (flush) begin
            exmem_we   = 1'b1;
            bubble     = 1'b1;
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (idex_valid && multi_cycle) begin
                        stall      = 1'b1;
                        issue      = 1'b1;
                        state_next = BUSY;
                    end else if (idex_valid) begin
                        exmem_we = exmem_ready;
                        stall    = !exmem_ready;
                    end else begin
                        exmem_we = exmem_ready;
                        bubble   = exmem_ready;
                    end
                end
                BUSY: begin
                    if (alu_done && exmem_ready) begin
                        exmem_we   = 1'b1;
                        state_next = IDLE;
                    end else if (alu_done) begin
                        stall      = 1'b1;
                        state_next = DONE_WAIT;
                    end else if (expire) begin
                        exmem_we   = 1'b1;
                        bubble     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                DONE_WAIT: begin
                    if (exmem_ready) begin
                        exmem_we   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_start  <= 1'b0;
            alu_opcode <= '0;
        end else begin
            state     <= state_next;
            alu_start <= issue;
            if (issue) begin
                alu_opcode <= opcode;
            end
        end
    end

`ifdef EX_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (in_busy && expire && !alu_done && !flush) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ex_seq_ctrl.sv
// Directed and randomized bench for ex_seq_ctrl against a transaction-level reference model.
// Define EX_SEQ_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 8).
module tb_ex_seq_ctrl;

    localparam int OPC_W = 6;
    localparam int TMO   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             idex_valid;
    logic [OPC_W-1:0] opcode;
    logic             multi_cycle;
    logic             alu_done;
    logic             flush;
    logic             exmem_ready;
    logic             alu_start;
    logic [OPC_W-1:0] alu_opcode;
    logic             stall;
    logic             exmem_we;
    logic             bubble;
    logic [7:0]       busy_cycles;
    logic             timeout_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: an op is "active" from issue until its result (or a bubble) is written;
    // "result_held" means the ALU has answered but EXMEM has not taken it yet.
    bit             m_active;
    bit             m_result_held;
    bit             m_start;
    bit             m_err;
    logic [OPC_W-1:0] m_opc;
    int             m_busy;
    bit             e_stall, e_we, e_bubble;

    bit             n_active, n_result_held, n_start, n_err;
    logic [OPC_W-1:0] n_opc;
    int             n_busy;

    always #5 clk = ~clk;

    ex_seq_ctrl #(
        .OPC_W          (OPC_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .idex_valid  (idex_valid),
        .opcode      (opcode),
        .multi_cycle (multi_cycle),
        .alu_done    (alu_done),
        .flush       (flush),
        .exmem_ready (exmem_ready),
        .alu_start   (alu_start),
        .alu_opcode  (alu_opcode),
        .stall       (stall),
        .exmem_we    (exmem_we),
        .bubble      (bubble),
        .busy_cycles (busy_cycles),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active      = 0;
        m_result_held = 0;
        m_start       = 0;
        m_err         = 0;
        m_opc         = '0;
        m_busy        = 0;
    endtask

    task automatic model_eval();
        bit waiting_alu;
        waiting_alu   = m_active && !m_result_held;
        e_stall       = 0;
        e_we          = 0;
        e_bubble      = 0;
        n_active      = m_active;
        n_result_held = m_result_held;
        n_start       = 0;
        n_err         = m_err;
        n_opc         = m_opc;
        n_busy        = waiting_alu ? ((m_busy < 255) ? m_busy + 1 : 255) : m_busy;
        if (flush) begin
            e_we          = 1;
            e_bubble      = 1;
            n_active      = 0;
            n_result_held = 0;
        end else if (!m_active) begin
            if (idex_valid && multi_cycle) begin
                e_stall  = 1;
                n_active = 1;
                n_start  = 1;
                n_opc    = opcode;
                n_busy   = 0;
            end else if (idex_valid) begin
                e_we    = exmem_ready;
                e_stall = !exmem_ready;
            end else begin
                e_we     = exmem_ready;
                e_bubble = exmem_ready;
            end
        end else if (!m_result_held) begin
            if (alu_done && exmem_ready) begin
                e_we     = 1;
                n_active = 0;
            end else if (alu_done) begin
                e_stall       = 1;
                n_result_held = 1;
`ifdef EX_SEQ_TIMEOUT_EN
            end else if (m_busy + 1 == TMO) begin
                e_we     = 1;
                e_bubble = 1;
                n_active = 0;
                n_err    = 1;
`endif
            end else begin
                e_stall = 1;
            end
        end else begin
            if (exmem_ready) begin
                e_we          = 1;
                n_active      = 0;
                n_result_held = 0;
            end else begin
                e_stall = 1;
            end
        end
    endtask

    task automatic check_output();
        chk("stall", stall, e_stall);
        chk("exmem_we", exmem_we, e_we);
        if (e_we) chk("bubble", bubble, e_bubble);
        chk("alu_start", alu_start, m_start);
        chk("alu_opcode", alu_opcode, m_opc);
        chk("busy_cycles", busy_cycles, m_busy);
        chk("timeout_err", timeout_err, m_err);
    endtask

    // Drives one cycle's inputs at the falling edge, checks mid-cycle, then advances the model.
    task automatic apply_stimulus(input bit v, input logic [OPC_W-1:0] opc, input bit mc,
                                  input bit done, input bit fl, input bit rdy);
        @(negedge clk);
        idex_valid  = v;
        opcode      = opc;
        multi_cycle = mc;
        alu_done    = done;
        flush       = fl;
        exmem_ready = rdy;
        #1;
        model_eval();
        check_output();
        m_active      = n_active;
        m_result_held = n_result_held;
        m_start       = n_start;
        m_err         = n_err;
        m_opc         = n_opc;
        m_busy        = n_busy;
    endtask

    initial begin
        int stall_seen;
        int we_seen;

        // Reset held with a valid single-cycle op waiting in IDEX
        rst_n       = 1'b0;
        idex_valid  = 1'b1;
        opcode      = 6'h11;
        multi_cycle = 1'b0;
        alu_done    = 1'b0;
        flush       = 1'b0;
        exmem_ready = 1'b1;
        model_reset();
        #12;
        chk("rst_alu_start", alu_start, 0);
        chk("rst_alu_opcode", alu_opcode, 0);
        chk("rst_busy_cycles", busy_cycles, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        apply_stimulus(1, 6'h11, 0, 0, 0, 1);
        chk("single_we", exmem_we, 1);
        chk("single_stall", stall, 0);

        // Multi-cycle op 0x0A, alu_done three cycles after alu_start
        stall_seen = 0;
        apply_stimulus(1, 6'h0A, 1, 0, 0, 1);
        stall_seen += int'(stall);
        apply_stimulus(1, 6'h0A, 1, 0, 0, 1);
        chk("mc_start_pulse", alu_start, 1);
        stall_seen += int'(stall);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1, 6'h0A, 1, 0, 0, 1);
            chk("mc_opcode_hold", alu_opcode, 6'h0A);
            stall_seen += int'(stall);
        end
        apply_stimulus(1, 6'h0A, 1, 1, 0, 1);
        chk("mc_we_on_done", exmem_we, 1);
        stall_seen += int'(stall);
        chk("mc_stall_cycles", stall_seen, 4);
        apply_stimulus(0, 6'h00, 0, 0, 0, 1);
        chk("mc_busy_cycles", busy_cycles, 4);
        chk("mc_opcode_after", alu_opcode, 6'h0A);

        // Back-pressure: result arrives with EXMEM not ready for two cycles
        we_seen    = 0;
        stall_seen = 0;
        apply_stimulus(1, 6'h15, 1, 0, 0, 0);
        apply_stimulus(1, 6'h15, 1, 1, 0, 0);
        we_seen += int'(exmem_we); stall_seen += int'(stall);
        apply_stimulus(1, 6'h15, 1, 0, 0, 0);
        we_seen += int'(exmem_we); stall_seen += int'(stall);
        apply_stimulus(1, 6'h15, 1, 0, 0, 1);
        we_seen += int'(exmem_we);
        chk("bp_stall_held", stall_seen, 2);
        chk("bp_single_write", we_seen, 1);
        chk("bp_release_stall", stall, 0);

        // Flush coincident with alu_done in BUSY
        apply_stimulus(1, 6'h2C, 1, 0, 0, 1);
        apply_stimulus(1, 6'h2C, 1, 1, 1, 1);
        chk("fl_bubble", bubble, 1);
        chk("fl_we", exmem_we, 1);
        apply_stimulus(0, 6'h00, 0, 1, 0, 0);
        chk("fl_idle_no_we", exmem_we, 0);
        chk("fl_idle_no_stall", stall, 0);

        // Long BUSY with no alu_done: watchdog aborts only when compiled in
        apply_stimulus(1, 6'h3F, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++) apply_stimulus(1, 6'h3F, 1, 0, 0, 1);
`ifdef EX_SEQ_TIMEOUT_EN
        chk("wd_flag_set", timeout_err, 1);
        apply_stimulus(0, 6'h00, 0, 0, 0, 1);
        chk("wd_flag_sticky", timeout_err, 1);
        rst_n = 1'b0;
        #1;
        chk("wd_flag_cleared", timeout_err, 0);
        model_reset();
        rst_n = 1'b1;
`else
        chk("nowd_flag_low", timeout_err, 0);
        chk("nowd_still_stall", stall, 1);
        apply_stimulus(1, 6'h3F, 1, 1, 0, 1);
`endif

        // Asynchronous reset in the middle of BUSY
        apply_stimulus(1, 6'h07, 1, 0, 0, 1);
        apply_stimulus(1, 6'h07, 1, 0, 0, 1);
        apply_stimulus(1, 6'h07, 1, 0, 0, 1);
        idex_valid  = 1'b0;
        alu_done    = 1'b0;
        flush       = 1'b0;
        exmem_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", stall, 0);
        chk("arst_we", exmem_we, 0);
        chk("arst_busy_cycles", busy_cycles, 0);
        chk("arst_alu_start", alu_start, 0);
        model_reset();
        #1;
        rst_n = 1'b1;

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 3) != 0,
                           OPC_W'($urandom_range(0, 63)),
                           $urandom_range(0, 4) < 2,
                           $urandom_range(0, 9) < 3,
                           $urandom_range(0, 19) == 0,
                           $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_seq_ctrl.md
# ex_seq_ctrl

Sequencing controller for the EX stage. Issues multi-cycle ALU operations (multiply/divide class), holds the opcode stable while the ALU runs, and stalls PC/IFID/IDEX until the result is accepted. It also gates loading of the EXMEM register against back-pressure and pipeline flushes. It sits between the IDEX register, the EX unit's ALU (`alu_done`) and the EXMEM register.

## Interface
Parameters:
- `OPC_W`, 6, opcode width
- `TIMEOUT_CYCLES`, 64, BUSY cycles before watchdog abort (only used when the watchdog is compiled in)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `idex_valid`  in  1  IDEX holds a valid instruction
- `opcode`  in  OPC_W  opcode from IDEX
- `multi_cycle`  in  1  decoded op needs the multi-cycle ALU path
- `alu_done`  in  1  ALU result valid this cycle
- `flush`  in  1  branch/ret redirect; kills in-flight op
- `exmem_ready`  in  1  EXMEM register can load this cycle
- `alu_start`  out  1  one-cycle start pulse to ALU
- `alu_opcode`  out  OPC_W  latched opcode, stable throughout BUSY
- `stall`  out  1  freeze PC, IFID, IDEX
- `exmem_we`  out  1  load EXMEM this cycle
- `bubble`  out  1  EXMEM loads a NOP (valid only with `exmem_we`)
- `busy_cycles`  out  8  BUSY duration of last multi-cycle op, saturating at 255
- `timeout_err`  out  1  sticky watchdog flag

## Operation
States: IDLE, BUSY, DONE_WAIT.

- **IDLE**
  - `idex_valid & !multi_cycle`: `exmem_we = exmem_ready`; `stall = !exmem_ready`.
  - `idex_valid & multi_cycle`: latch `opcode` into `alu_opcode`, `stall = 1`, go to BUSY.
  - `!idex_valid`: if `exmem_ready`, `exmem_we = 1` and `bubble = 1`.
  - `alu_done` is ignored in IDLE.
- **BUSY**
  - `alu_start = 1` on the first BUSY cycle only.
  - `alu_done & exmem_ready`: `exmem_we = 1`, `stall = 0`, go to IDLE.
  - `alu_done & !exmem_ready`: `stall = 1`, go to DONE_WAIT.
  - Otherwise: `stall = 1`, remain in BUSY.
- **DONE_WAIT**: `stall = !exmem_ready`. When `exmem_ready`: `exmem_we = 1`, go to IDLE.
- **flush** (any state, highest priority):
  - `exmem_we = 1`, `bubble = 1`, `stall = 0`; next state is IDLE.
  - A simultaneous `alu_done` is discarded.
- **busy_cycles**: cleared on entry to BUSY, +1 per BUSY cycle (start cycle counts as 1), saturates at 255, then held until the next entry to BUSY.
- All of `stall`, `exmem_we`, `bubble` are combinational from state and inputs. `alu_start`, `alu_opcode`, `busy_cycles`, `timeout_err` are registered.
- **Reset**: state IDLE; `alu_opcode = 0`, `busy_cycles = 0`, `timeout_err = 0`, `alu_start = 0`. Combinational outputs follow IDLE rules immediately.
- Reset asserted mid-operation aborts the op; no EXMEM write results from it.

## Timing
- Multi-cycle issue in cycle N: `stall = 1` in N; BUSY and `alu_start` in N+1.
- `alu_done` is legal from N+1 onward, including the same cycle as `alu_start`.
- Minimum multi-cycle occupancy: 2 cycles (N, N+1) with `stall` high in N only, deasserting in N+1 if `alu_done & exmem_ready`.
- Single-cycle op with `exmem_ready`: zero stall, `exmem_we` in the same cycle.
- Back-pressure: each `!exmem_ready` cycle extends the stall by exactly one cycle.

## Configuration
- `EX_SEQ_TIMEOUT_EN` defined:
  - A watchdog counts BUSY cycles.
  - Reaching `TIMEOUT_CYCLES` without `alu_done` sets `timeout_err` (sticky until reset), forces `exmem_we = 1` and `bubble = 1` that cycle, and returns to IDLE.
- Undefined: no watchdog; BUSY waits indefinitely; `timeout_err` tied to 0.

## Structure
- Package `ex_ctrl_pkg`: state enum (IDLE/BUSY/DONE_WAIT), `OPC_W`, default `TIMEOUT_CYCLES`, 8-bit cycle-count width constant.
- One sub-module: `ex_seq_timer`, holding the saturating `busy_cycles` counter and the watchdog compare. Interface: clear, enable, count out, expire pulse.
- FSM and output decode stay in `ex_seq_ctrl`.

## Test plan
- Reset with `idex_valid = 1` held: all registered outputs 0 → after release, single-cycle op with `exmem_ready = 1` gives `exmem_we = 1` and `stall = 0` in the same cycle.
- Multi-cycle op, opcode 6'h0A, `alu_done` 3 cycles after `alu_start`:
  - `alu_opcode = 6'h0A` throughout.
  - `stall` high 4 cycles.
  - `exmem_we` on the `alu_done` cycle.
  - `busy_cycles = 4`.
- `alu_done` while `exmem_ready = 0` for 2 cycles → DONE_WAIT, stall held 2 extra cycles, one `exmem_we` when ready returns.
- `flush` coincident with `alu_done` in BUSY → `bubble = 1`, `exmem_we = 1`, IDLE next; no non-bubble write.
- With `EX_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES = 8`, no `alu_done` → `timeout_err = 1` after 8 BUSY cycles, bubble written, IDLE; flag persists until `rst_n` is low.
- `rst_n` asserted asynchronously mid-BUSY → immediate IDLE, `stall = 0`, `busy_cycles = 0`, no `exmem_we` from the aborted op.
